// File: rtl/smi_mem_lib_read_arbiter_x2.sv
// rtl/smi_mem_lib_read_arbiter_x2.sv - two-requester arbiter in front of one shared read-burst engine
//
// Purpose:
//   Grants one of two requesters (A, B) access to a single segmented
//   read-burst engine. Only one transaction is outstanding at a time. The
//   burst parameters are captured at grant and re-issued to the engine one
//   cycle later. Read data and done are then steered combinationally to the
//   owner. Priority alternates after every completed transaction, and A wins
//   the first tie after reset.
//
// Ports:
//   clk, srst                     clock, synchronous active-high reset
//   paramsValid{A,B}              requester burst request valid
//   paramBurstAddr{A,B} [63:0]    burst start address
//   paramBurstLen{A,B}  [31:0]    burst length in 64-bit words
//   paramBurstOpts{A,B} [7:0]     burst options, passed through unchanged
//   paramsStop{A,B}               request back-pressure to requester
//   readValid{A,B}, readData{A,B} read beats to requester
//   readStop{A,B}                 read back-pressure from requester
//   doneValid{A,B}, doneStatusOk{A,B}  completion to requester
//   doneStop{A,B}                 completion back-pressure from requester
//   eng*                          mirror-image handshakes toward the engine
//
// Optional feature macro: SMI_READ_ARB_BEAT_CHECK_EN
//   When defined, owner data transfers are counted. The engine done is
//   latched and replayed from a DONE state, with the status also requiring
//   beat count == requested length. This adds one cycle of done latency.

module smi_mem_lib_read_arbiter_x2 (
  input  logic        clk,
  input  logic        srst,

  input  logic        paramsValidA,
  input  logic [63:0] paramBurstAddrA,
  input  logic [31:0] paramBurstLenA,
  input  logic [7:0]  paramBurstOptsA,
  output logic        paramsStopA,
  output logic        readValidA,
  output logic [63:0] readDataA,
  input  logic        readStopA,
  output logic        doneValidA,
  output logic        doneStatusOkA,
  input  logic        doneStopA,

  input  logic        paramsValidB,
  input  logic [63:0] paramBurstAddrB,
  input  logic [31:0] paramBurstLenB,
  input  logic [7:0]  paramBurstOptsB,
  output logic        paramsStopB,
  output logic        readValidB,
  output logic [63:0] readDataB,
  input  logic        readStopB,
  output logic        doneValidB,
  output logic        doneStatusOkB,
  input  logic        doneStopB,

  output logic        engParamsValid,
  output logic [63:0] engBurstAddr,
  output logic [31:0] engBurstLen,
  output logic [7:0]  engBurstOpts,
  input  logic        engParamsStop,
  input  logic        engReadValid,
  input  logic [63:0] engReadData,
  output logic        engReadStop,
  input  logic        engDoneValid,
  input  logic        engDoneStatusOk,
  output logic        engDoneStop
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;    // 0 = A wins a tie, 1 = B wins a tie
  logic        owner_q, owner_d;  // 0 = A owns the engine, 1 = B
  logic [63:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [7:0]  opts_q, opts_d;

`ifdef SMI_READ_ARB_BEAT_CHECK_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        done_ok_q, done_ok_d;
`endif

  logic win_valid;
  logic win_b;
  logic own_read_stop;
  logic own_done_stop;

  // The tie goes to prio; otherwise the single valid requester wins.
  assign win_valid     = paramsValidA | paramsValidB;
  assign win_b         = (paramsValidA & paramsValidB) ? prio_q : paramsValidB;
  assign own_read_stop = owner_q ? readStopB : readStopA;
  assign own_done_stop = owner_q ? doneStopB : doneStopA;

  // Data is broadcast; only the owner's readValid qualifies it.
  assign readDataA    = engReadData;
  assign readDataB    = engReadData;
  assign engBurstAddr = addr_q;
  assign engBurstLen  = len_q;
  assign engBurstOpts = opts_q;

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    len_d          = len_q;
    opts_d         = opts_q;
`ifdef SMI_READ_ARB_BEAT_CHECK_EN
    beat_cnt_d     = beat_cnt_q;
    done_ok_d      = done_ok_q;
`endif
    paramsStopA    = 1'b1;
    paramsStopB    = 1'b1;
    engParamsValid = 1'b0;
    readValidA     = 1'b0;
    readValidB     = 1'b0;
    engReadStop    = 1'b1;
    doneValidA     = 1'b0;
    doneValidB     = 1'b0;
    doneStatusOkA  = 1'b0;
    doneStatusOkB  = 1'b0;
    engDoneStop    = 1'b1;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          // The winner sees stop=0, so a transfer is guaranteed this cycle.
          if (win_b) begin
            paramsStopB = 1'b0;
            addr_d      = paramBurstAddrB;
            len_d       = paramBurstLenB;
            opts_d      = paramBurstOptsB;
          end else begin
            paramsStopA = 1'b0;
            addr_d      = paramBurstAddrA;
            len_d       = paramBurstLenA;
            opts_d      = paramBurstOptsA;
          end
          owner_d = win_b;
          state_d = ISSUE;
`ifdef SMI_READ_ARB_BEAT_CHECK_EN
          beat_cnt_d = 32'd0;
`endif
        end
      end

      ISSUE: begin
        engParamsValid = 1'b1;
        if (!engParamsStop) begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        engReadStop = own_read_stop;
        readValidA  = engReadValid & ~owner_q;
        readValidB  = engReadValid &  owner_q;
`ifdef SMI_READ_ARB_BEAT_CHECK_EN
        if (engReadValid && !own_read_stop) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
        end
        // Done is always accepted here and replayed from DONE. The compare
        // uses beat_cnt_d so that a beat arriving with done is counted.
        engDoneStop = 1'b0;
        if (engDoneValid) begin
          done_ok_d = engDoneStatusOk && (beat_cnt_d == len_q);
          state_d   = DONE;
        end
`else
        engDoneStop   = own_done_stop;
        doneValidA    = engDoneValid & ~owner_q;
        doneValidB    = engDoneValid &  owner_q;
        doneStatusOkA = engDoneStatusOk & ~owner_q;
        doneStatusOkB = engDoneStatusOk &  owner_q;
        if (engDoneValid && !own_done_stop) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
`endif
      end

      DONE: begin
`ifdef SMI_READ_ARB_BEAT_CHECK_EN
        doneValidA    = ~owner_q;
        doneValidB    =  owner_q;
        doneStatusOkA = done_ok_q & ~owner_q;
        doneStatusOkB = done_ok_q &  owner_q;
        if (!own_done_stop) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    // Keep every handshake quiet during the reset cycle, whatever state we
    // were in when reset arrived.
    if (srst) begin
      paramsStopA    = 1'b1;
      paramsStopB    = 1'b1;
      engParamsValid = 1'b0;
      readValidA     = 1'b0;
      readValidB     = 1'b0;
      engReadStop    = 1'b1;
      doneValidA     = 1'b0;
      doneValidB     = 1'b0;
      doneStatusOkA  = 1'b0;
      doneStatusOkB  = 1'b0;
      engDoneStop    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
    // Captured datapath is only meaningful after a grant, so it has no reset.
    owner_q <= owner_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    opts_q  <= opts_d;
`ifdef SMI_READ_ARB_BEAT_CHECK_EN
    beat_cnt_q <= beat_cnt_d;
    done_ok_q  <= done_ok_d;
`endif
  end

endmodule

// File: tb/tb_smi_mem_lib_read_arbiter_x2.sv
// tb/tb_smi_mem_lib_read_arbiter_x2.sv - self-checking bench for smi_mem_lib_read_arbiter_x2
module tb_smi_mem_lib_read_arbiter_x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        paramsValidA, paramsValidB;
  logic [63:0] paramBurstAddrA, paramBurstAddrB;
  logic [31:0] paramBurstLenA, paramBurstLenB;
  logic [7:0]  paramBurstOptsA, paramBurstOptsB;
  logic        paramsStopA, paramsStopB;
  logic        readValidA, readValidB;
  logic [63:0] readDataA, readDataB;
  logic        readStopA, readStopB;
  logic        doneValidA, doneValidB, doneStatusOkA, doneStatusOkB;
  logic        doneStopA, doneStopB;
  logic        engParamsValid;
  logic [63:0] engBurstAddr;
  logic [31:0] engBurstLen;
  logic [7:0]  engBurstOpts;
  logic        engParamsStop, engReadValid, engReadStop;
  logic [63:0] engReadData;
  logic        engDoneValid, engDoneStatusOk, engDoneStop;

  smi_mem_lib_read_arbiter_x2 dut (
    .clk(clk), .srst(srst),
    .paramsValidA(paramsValidA), .paramBurstAddrA(paramBurstAddrA),
    .paramBurstLenA(paramBurstLenA), .paramBurstOptsA(paramBurstOptsA),
    .paramsStopA(paramsStopA), .readValidA(readValidA), .readDataA(readDataA),
    .readStopA(readStopA), .doneValidA(doneValidA), .doneStatusOkA(doneStatusOkA),
    .doneStopA(doneStopA),
    .paramsValidB(paramsValidB), .paramBurstAddrB(paramBurstAddrB),
    .paramBurstLenB(paramBurstLenB), .paramBurstOptsB(paramBurstOptsB),
    .paramsStopB(paramsStopB), .readValidB(readValidB), .readDataB(readDataB),
    .readStopB(readStopB), .doneValidB(doneValidB), .doneStatusOkB(doneStatusOkB),
    .doneStopB(doneStopB),
    .engParamsValid(engParamsValid), .engBurstAddr(engBurstAddr),
    .engBurstLen(engBurstLen), .engBurstOpts(engBurstOpts),
    .engParamsStop(engParamsStop), .engReadValid(engReadValid),
    .engReadData(engReadData), .engReadStop(engReadStop),
    .engDoneValid(engDoneValid), .engDoneStatusOk(engDoneStatusOk),
    .engDoneStop(engDoneStop)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // {psA, psB, engParamsValid, rvA, rvB, engReadStop, dvA, dvB, engDoneStop}
  function automatic logic [8:0] flags();
    return {paramsStopA, paramsStopB, engParamsValid, readValidA, readValidB,
            engReadStop, doneValidA, doneValidB, engDoneStop};
  endfunction

  localparam logic [8:0] QUIET = 9'b110001001;

  typedef struct {
    logic va, vb;
    logic [31:0] la, lb;
    logic eps, erv;
    logic [63:0] erd;
    logic rsa, rsb, edv, edok, dsa, dsb;
    logic [8:0] ef;
    logic [31:0] elen;
    logic eok;
  } vec_t;

  function automatic vec_t mk(input logic va, vb, input logic [31:0] la, lb,
                              input logic eps, erv, input logic [63:0] erd,
                              input logic rsa, rsb, edv, edok, dsa, dsb,
                              input logic [8:0] ef, input logic [31:0] elen,
                              input logic eok);
    vec_t v;
    v.va = va; v.vb = vb; v.la = la; v.lb = lb; v.eps = eps; v.erv = erv;
    v.erd = erd; v.rsa = rsa; v.rsb = rsb; v.edv = edv; v.edok = edok;
    v.dsa = dsa; v.dsb = dsb; v.ef = ef; v.elen = elen; v.eok = eok;
    return v;
  endfunction

  task automatic drive_idle();
    paramsValidA = 0; paramsValidB = 0;
    paramBurstAddrA = 64'h0; paramBurstAddrB = 64'h0;
    paramBurstLenA = 32'h0; paramBurstLenB = 32'h0;
    paramBurstOptsA = 8'h0; paramBurstOptsB = 8'h0;
    readStopA = 0; readStopB = 0; doneStopA = 0; doneStopB = 0;
    engParamsStop = 0; engReadValid = 0; engReadData = 64'h0;
    engDoneValid = 0; engDoneStatusOk = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    drive_idle();
    srst = 1;
    #1 chk({tag, "_flags_in_reset"}, {55'd0, flags()}, {55'd0, QUIET});
    @(negedge clk);
    srst = 0;
  endtask

  task automatic run_burst(input logic b, input logic [63:0] addr, input logic [31:0] len,
                           input int nbeats, input int stall_at, input int stall_len,
                           input logic exp_ok, input string tag);
    int i, stall_cnt, other_beats, order_err, stop_err;
    bit granted, done_seen, eng_done_sent;
    logic st, rv_own, rv_oth;
    logic [63:0] rd_own;
    granted = 0;
    for (int to = 0; to < 10 && !granted; to++) begin
      @(negedge clk);
      drive_idle();
      if (b) begin
        paramsValidB = 1; paramBurstAddrB = addr; paramBurstLenB = len; paramBurstOptsB = 8'h5a;
      end else begin
        paramsValidA = 1; paramBurstAddrA = addr; paramBurstLenA = len; paramBurstOptsA = 8'h5a;
      end
      #1 granted = b ? !paramsStopB : !paramsStopA;
    end
    chk({tag, "_grant"}, {63'd0, granted}, 64'd1);
    @(negedge clk);
    drive_idle();
    #1;
    chk({tag, "_eng_valid_1cyc"}, {63'd0, engParamsValid}, 64'd1);
    chk({tag, "_eng_len"}, {32'd0, engBurstLen}, {32'd0, len});
    chk({tag, "_eng_addr"}, engBurstAddr, addr);
    chk({tag, "_eng_opts"}, {56'd0, engBurstOpts}, 64'h5a);
    i = 0; stall_cnt = 0; other_beats = 0; order_err = 0; stop_err = 0;
    for (int cyc = 0; cyc < nbeats + stall_len + 5 && i < nbeats; cyc++) begin
      @(negedge clk);
      drive_idle();
      engReadValid = 1;
      engReadData = addr + 64'(i);
      st = (i == stall_at) && (stall_cnt < stall_len);
      if (st) stall_cnt++;
      if (b) readStopB = st; else readStopA = st;
      #1;
      rv_own = b ? readValidB : readValidA;
      rv_oth = b ? readValidA : readValidB;
      rd_own = b ? readDataB : readDataA;
      if (engReadStop !== st) stop_err++;
      if (rv_oth) other_beats++;
      if (rv_own && !st) begin
        if (rd_own !== addr + 64'(i)) order_err++;
        i++;
      end
    end
    chk({tag, "_beat_count"}, 64'(i), 64'(nbeats));
    chk({tag, "_order_errors"}, 64'(order_err), 64'd0);
    chk({tag, "_eng_read_stop_errors"}, 64'(stop_err), 64'd0);
    done_seen = 0; eng_done_sent = 0;
    for (int cyc = 0; cyc < 6 && !done_seen; cyc++) begin
      @(negedge clk);
      drive_idle();
      engDoneValid = !eng_done_sent;
      engDoneStatusOk = 1;
      #1;
      if (b ? (doneValidA || readValidA) : (doneValidB || readValidB)) other_beats++;
      if (b ? doneValidB : doneValidA) begin
        done_seen = 1;
        chk({tag, "_done_status"}, {63'd0, b ? doneStatusOkB : doneStatusOkA}, {63'd0, exp_ok});
      end
      if (engDoneValid && !engDoneStop) eng_done_sent = 1;
    end
    chk({tag, "_done_seen"}, {63'd0, done_seen}, 64'd1);
    chk({tag, "_non_owner_activity"}, 64'(other_beats), 64'd0);
    @(negedge clk);
    drive_idle();
  endtask

  vec_t tbl[19];

  initial begin
    srst = 1;
    drive_idle();

`ifndef SMI_READ_ARB_BEAT_CHECK_EN
    // Round 1: tie after reset -> A (len 4). Round 2: tie -> B (len 2), with
    // last beat and done together. Round 3: tie -> A again.
    tbl[0]  = mk(1,1,4,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b010001001, 0, 0);
    tbl[1]  = mk(0,1,4,2, 1,0,64'h0,  0,0,0,0,0,0, 9'b111001001, 4, 0);
    tbl[2]  = mk(0,1,4,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b111001001, 4, 0);
    tbl[3]  = mk(0,1,0,0, 0,1,64'hA0, 0,0,0,0,0,0, 9'b110100000, 0, 0);
    tbl[4]  = mk(0,1,0,0, 0,1,64'hA1, 1,0,0,0,0,0, 9'b110101000, 0, 0);
    tbl[5]  = mk(0,1,0,0, 0,1,64'hA1, 0,0,0,0,0,0, 9'b110100000, 0, 0);
    tbl[6]  = mk(0,1,0,0, 0,0,64'h0,  0,0,0,0,0,0, 9'b110000000, 0, 0);
    tbl[7]  = mk(0,1,0,0, 0,1,64'hA2, 0,0,0,0,0,0, 9'b110100000, 0, 0);
    tbl[8]  = mk(0,1,0,0, 0,1,64'hA3, 0,0,0,0,0,0, 9'b110100000, 0, 0);
    tbl[9]  = mk(0,1,0,0, 0,0,64'h0,  0,0,1,1,1,0, 9'b110000101, 0, 1);
    tbl[10] = mk(0,1,0,0, 0,0,64'h0,  0,0,1,1,0,0, 9'b110000100, 0, 1);
    tbl[11] = mk(1,1,7,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b100001001, 0, 0);
    tbl[12] = mk(1,0,7,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b111001001, 2, 0);
    tbl[13] = mk(1,0,7,0, 0,1,64'hB0, 0,0,0,0,0,0, 9'b110010000, 0, 0);
    tbl[14] = mk(1,0,7,0, 0,1,64'hB1, 0,0,1,0,0,0, 9'b110010010, 0, 0);
    tbl[15] = mk(1,1,7,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b010001001, 0, 0);
    tbl[16] = mk(0,1,7,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b111001001, 7, 0);
    tbl[17] = mk(0,1,0,0, 0,0,64'h0,  0,0,1,1,0,0, 9'b110000100, 0, 1);
    tbl[18] = mk(0,1,0,2, 0,0,64'h0,  0,0,0,0,0,0, 9'b100001001, 0, 0);
`endif

    do_reset("reset0");

`ifndef SMI_READ_ARB_BEAT_CHECK_EN
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      paramsValidA = tbl[k].va; paramsValidB = tbl[k].vb;
      paramBurstLenA = tbl[k].la; paramBurstLenB = tbl[k].lb;
      engParamsStop = tbl[k].eps; engReadValid = tbl[k].erv; engReadData = tbl[k].erd;
      readStopA = tbl[k].rsa; readStopB = tbl[k].rsb;
      engDoneValid = tbl[k].edv; engDoneStatusOk = tbl[k].edok;
      doneStopA = tbl[k].dsa; doneStopB = tbl[k].dsb;
      #1;
      chk($sformatf("vec%0d_flags", k), {55'd0, flags()}, {55'd0, tbl[k].ef});
      if (tbl[k].ef[6]) chk($sformatf("vec%0d_eng_len", k), {32'd0, engBurstLen}, {32'd0, tbl[k].elen});
      if (tbl[k].ef[5]) chk($sformatf("vec%0d_dataA", k), readDataA, tbl[k].erd);
      if (tbl[k].ef[4]) chk($sformatf("vec%0d_dataB", k), readDataB, tbl[k].erd);
      if (tbl[k].ef[2]) chk($sformatf("vec%0d_okA", k), {63'd0, doneStatusOkA}, {63'd0, tbl[k].eok});
      if (tbl[k].ef[1]) chk($sformatf("vec%0d_okB", k), {63'd0, doneStatusOkB}, {63'd0, tbl[k].eok});
    end
`endif

    do_reset("reset1");
    run_burst(1'b1, 64'h1000, 32'd0, 0, -1, 0, 1'b1, "zero_len_b");
    run_burst(1'b0, 64'h2000, 32'd8, 8, 3, 5, 1'b1, "stall_a");

    // prio now favours B; reset mid-stream must restore A-first.
    @(negedge clk);
    drive_idle();
    paramsValidB = 1; paramBurstLenB = 32'd4; paramBurstAddrB = 64'h4000;
    #1 chk("midrst_grant_b", {63'd0, paramsStopB}, 64'd0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    drive_idle();
    engReadValid = 1; engReadData = 64'h4000;
    #1 chk("midrst_streaming_b", {63'd0, readValidB}, 64'd1);
    @(negedge clk);
    srst = 1; engReadValid = 1; engDoneValid = 1; engDoneStatusOk = 1;
    #1 chk("midrst_flags_in_reset", {55'd0, flags()}, {55'd0, QUIET});
    @(negedge clk);
    srst = 0;
    #1 chk("midrst_flags_after", {55'd0, flags()}, {55'd0, QUIET});
    @(negedge clk);
    drive_idle();
    paramsValidA = 1; paramsValidB = 1; paramBurstLenA = 32'd3; paramBurstLenB = 32'd9;
    #1 chk("midrst_tie_to_a", {55'd0, flags()}, {55'd0, 9'b010001001});
    @(negedge clk);
    drive_idle();
    #1 chk("midrst_issue_len_a", {32'd0, engBurstLen}, 64'd3);

`ifdef SMI_READ_ARB_BEAT_CHECK_EN
    do_reset("reset2");
    run_burst(1'b0, 64'h3000, 32'd4, 3, -1, 0, 1'b0, "short_a");
    run_burst(1'b0, 64'h3100, 32'd4, 4, -1, 0, 1'b1, "exact_a");
`endif

    do_reset("reset_end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
